// File: rtl/modelbuf_read_arbiter_pkg.sv
// modelbuf_read_arbiter_pkg: model-buffer read/response types and arbiter limits
package modelbuf_read_arbiter_pkg;
    localparam int MODELBUF_ARB_MAX_REQ = 8;
    typedef logic [$clog2(MODELBUF_ARB_MAX_REQ)-1:0] arb_tag_t;
    typedef struct packed {
        logic [7:0]  model_index;
        logic [15:0] triangle_index;
    } modelbuf_read_t;
    typedef struct packed {
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] v2;
    } triangle_t;
    typedef struct packed {
        logic last;
    } triangle_meta_t;
endpackage

// File: rtl/modelbuf_read_arbiter_tag_fifo.sv
// modelbuf_read_arbiter_tag_fifo: synchronous tag FIFO, extra pointer bit distinguishes full from empty
module modelbuf_read_arbiter_tag_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head = mem[rd_ptr[AW-1:0]];
    // pointers only move on legal operations so occupancy can never wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + ONE;
            if (pop && !empty) rd_ptr <= rd_ptr + ONE;
        end
    end
    // storage is never read before written, so it carries no reset
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/modelbuf_read_arbiter.sv
// modelbuf_read_arbiter: round-robin sharing of the model buffer read port with in-order response routing
// Optional burst lock (grant held until the model's last triangle returns): define MODELBUF_ARB_LOCK_EN
module modelbuf_read_arbiter
    import modelbuf_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int TAG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  modelbuf_read_t       req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]   resp_valid,
    input  logic [NUM_REQ-1:0]   resp_ready,
    output triangle_t            resp_data,
    output triangle_meta_t       resp_metadata,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output modelbuf_read_t       mem_req_data,
    input  logic                 mem_resp_valid,
    output logic                 mem_resp_ready,
    input  triangle_t            mem_resp_data,
    input  triangle_meta_t       mem_resp_metadata
);
    localparam int PW = $clog2(NUM_REQ);
    typedef logic [PW-1:0] ptr_t;
    typedef logic [NUM_REQ-1:0] vec_t;

    if (NUM_REQ < 2 || NUM_REQ > MODELBUF_ARB_MAX_REQ) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..MODELBUF_ARB_MAX_REQ");
    end
    if (TAG_DEPTH < 2 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_bad_tag_depth
        $error("TAG_DEPTH must be a power of two >= 2");
    end

    ptr_t rr_ptr;
    arb_tag_t win, head;
    logic any, full, empty, push, pop;
    vec_t eff_valid, rot, win_oh, head_oh;

    function automatic ptr_t next_ptr(input arb_tag_t t);
        return (int'(t) + 1 >= NUM_REQ) ? '0 : ptr_t'(int'(t) + 1);
    endfunction

    // rotate so bit 0 is rr_ptr, take the lowest set bit, then map the offset back to an index
    always_comb begin
        int off, sum;
        rot = vec_t'({eff_valid, eff_valid} >> rr_ptr);
        off = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) off = k;
        sum = int'(rr_ptr) + off;
        win = arb_tag_t'(sum >= NUM_REQ ? sum - NUM_REQ : sum);
        any = |eff_valid;
    end

    // one-hot decode of winner and head tag; request mux follows the winner
    always_comb begin
        win_oh = '0;
        head_oh = '0;
        mem_req_data = req_data[0];
        for (int i = 0; i < NUM_REQ; i++) begin
            win_oh[i] = win == arb_tag_t'(i);
            head_oh[i] = head == arb_tag_t'(i);
            if (win_oh[i]) mem_req_data = req_data[i];
        end
    end

    assign mem_req_valid  = !rst && any && !full;
    assign req_ready      = (!rst && any && !full && mem_req_ready) ? win_oh : '0;
    assign push           = mem_req_valid && mem_req_ready;
    assign resp_valid     = (!rst && !empty && mem_resp_valid) ? head_oh : '0;
    assign mem_resp_ready = !rst && !empty && |(resp_ready & head_oh);
    assign pop            = mem_resp_valid && mem_resp_ready;
    assign resp_data      = mem_resp_data;
    assign resp_metadata  = mem_resp_metadata;

`ifdef MODELBUF_ARB_LOCK_EN
    logic locked, release_lock;
    arb_tag_t lock_id;
    vec_t lock_oh;

    // only the lock holder may compete while a burst is open
    always_comb begin
        lock_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) lock_oh[i] = lock_id == arb_tag_t'(i);
    end

    assign eff_valid = locked ? (req_valid & lock_oh) : req_valid;
    assign release_lock = locked && pop && mem_resp_metadata.last && head == lock_id;

    // lock onto the first winner; move rr_ptr past it only once its last triangle is delivered
    always_ff @(posedge clk) begin
        if (rst) begin
            locked <= 1'b0;
            lock_id <= '0;
            rr_ptr <= '0;
        end else begin
            if (push && !locked) begin
                locked <= 1'b1;
                lock_id <= win;
            end else if (release_lock && !push) begin
                locked <= 1'b0;
            end
            if (release_lock) rr_ptr <= next_ptr(lock_id);
        end
    end
`else
    assign eff_valid = req_valid;

    // advance past the winner on every accepted request
    always_ff @(posedge clk) begin
        if (rst) rr_ptr <= '0;
        else if (push) rr_ptr <= next_ptr(win);
    end
`endif

    modelbuf_read_arbiter_tag_fifo #(
        .WIDTH($bits(arb_tag_t)),
        .DEPTH(TAG_DEPTH)
    ) u_tags (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (win),
        .head (head),
        .full (full),
        .empty(empty)
    );
endmodule
